// File: rtl/ifu_prefetch_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// Requests carry an address plus a full-PC tag; responses return data with the
// tag of the request they answer, strictly in request order.
interface ifu_prefetch_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 16,
    parameter int INSTR_LEN = 32
);
    logic [ADDR_W-1:0]    instr_mem_addr;
    logic                 instr_mem_addr_valid;
    logic                 instr_mem_addr_ready;
    logic [XLEN-1:0]      instr_mem_tag_out;
    logic [INSTR_LEN-1:0] instr_mem_rdata;
    logic                 instr_mem_rdata_valid;
    logic [XLEN-1:0]      instr_mem_tag_in;

    modport master (
        output instr_mem_addr,
        output instr_mem_addr_valid,
        output instr_mem_tag_out,
        input  instr_mem_addr_ready,
        input  instr_mem_rdata,
        input  instr_mem_rdata_valid,
        input  instr_mem_tag_in
    );

    modport slave (
        input  instr_mem_addr,
        input  instr_mem_addr_valid,
        input  instr_mem_tag_out,
        output instr_mem_addr_ready,
        output instr_mem_rdata,
        output instr_mem_rdata_valid,
        output instr_mem_tag_in
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Decoupled instruction-fetch unit with credit-based issue and a small fetch
// queue (FQ). Keeps up to MAX_OUTST requests in flight, discards wrong-path
// responses after a redirect, and never lets the FQ overflow because a request
// is only issued when a free FQ slot is reserved for its response.
// Optional feature: define IFU_FQ_BYPASS_EN to forward a response straight to
// decode in the same cycle when the FQ is empty and decode is not stalled.
module ifu_prefetch #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 16,
    parameter int INSTR_LEN = 32,
    parameter int FQ_DEPTH  = 4,
    parameter int MAX_OUTST = 4,
    parameter int PC_INC    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      reset_vector,
    ifu_prefetch_if.master       mem,
    input  logic [XLEN-1:0]      pc_exu,
    input  logic                 pc_load,
    input  logic                 pipe_stall,
    output logic [INSTR_LEN-1:0] instr,
    output logic                 instr_valid,
    output logic [XLEN-1:0]      instr_tag
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int SUM_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [OUT_W-1:0] outst_reg, outst_next;
    logic [OUT_W-1:0] drop_reg, drop_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] fq_cnt_reg, fq_cnt_next;

    logic [INSTR_LEN-1:0] fq_data [FQ_DEPTH];
    logic [XLEN-1:0]      fq_tag  [FQ_DEPTH];

    logic             fq_empty;
    logic             rsp_valid;
    logic             rsp_drop;
    logic             rsp_keep;
    logic [SUM_W-1:0] credit_used;
    logic             issue_valid;
    logic             issue_fire;
    logic             bypass;
    logic             fq_push;
    logic             fq_pop;

    assign fq_empty = (fq_cnt_reg == '0);

    // A response seen with nothing outstanding (e.g. a leftover from before a
    // reset) is ignored rather than allowed to underflow the counters.
    assign rsp_valid = mem.instr_mem_rdata_valid && (outst_reg != '0);
    assign rsp_drop  = rsp_valid && (drop_reg != '0);
    assign rsp_keep  = rsp_valid && (drop_reg == '0);

    // Live requests (those whose data will be kept) each own one FQ slot.
    assign credit_used = SUM_W'(outst_reg) - SUM_W'(drop_reg) + SUM_W'(fq_cnt_reg);

    assign issue_valid = !rst && !pc_load
                       && (outst_reg < OUT_W'(MAX_OUTST))
                       && (credit_used < SUM_W'(FQ_DEPTH));
    assign issue_fire  = issue_valid && mem.instr_mem_addr_ready;

    assign mem.instr_mem_addr       = pc_reg[ADDR_W-1:0];
    assign mem.instr_mem_tag_out    = pc_reg;
    assign mem.instr_mem_addr_valid = issue_valid;

`ifdef IFU_FQ_BYPASS_EN
    assign bypass = fq_empty && rsp_keep && !pipe_stall && !pc_load;
`else
    assign bypass = 1'b0;
`endif

    assign fq_pop  = !rst && !fq_empty && !pc_load && !pipe_stall;
    assign fq_push = rsp_keep && !pc_load && !bypass;

    assign instr_valid = !rst && ((!fq_empty && !pc_load) || bypass);
    assign instr       = bypass ? mem.instr_mem_rdata  : fq_data[rd_ptr_reg];
    assign instr_tag   = bypass ? mem.instr_mem_tag_in : fq_tag[rd_ptr_reg];

    // Fetch-queue storage: one register pair per entry, written at the tail slot
    for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_fq
        logic [INSTR_LEN-1:0] data_reg;
        logic [XLEN-1:0]      tag_reg;
        logic                 wr_en;

        assign wr_en = fq_push && (wr_ptr_reg == PTR_W'(gi));

        // Capture a kept response when this entry is the current write slot
        always_ff @(posedge clk) begin
            if (wr_en) begin
                data_reg <= mem.instr_mem_rdata;
                tag_reg  <= mem.instr_mem_tag_in;
            end
        end

        assign fq_data[gi] = data_reg;
        assign fq_tag[gi]  = tag_reg;
    end

    // Next-state: redirect overrides issue, response bookkeeping and FQ traffic
    always_comb begin
        pc_next     = pc_reg;
        outst_next  = outst_reg;
        drop_next   = drop_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        fq_cnt_next = fq_cnt_reg;
        if (pc_load) begin
            // Everything still in flight after this cycle belongs to the old
            // path, including a response arriving right now.
            pc_next     = pc_exu;
            outst_next  = outst_reg - OUT_W'(rsp_valid);
            drop_next   = outst_next;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            fq_cnt_next = '0;
        end else begin
            if (issue_fire) begin
                pc_next = pc_reg + XLEN'(PC_INC);
            end
            outst_next = outst_reg + OUT_W'(issue_fire) - OUT_W'(rsp_valid);
            if (rsp_drop) begin
                drop_next = drop_reg - OUT_W'(1);
            end
            if (fq_push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (fq_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            fq_cnt_next = fq_cnt_reg + CNT_W'(fq_push) - CNT_W'(fq_pop);
        end
    end

    // State register with synchronous reset to the reset vector and empty FQ
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= reset_vector;
            outst_reg  <= '0;
            drop_reg   <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            fq_cnt_reg <= '0;
        end else begin
            pc_reg     <= pc_next;
            outst_reg  <= outst_next;
            drop_reg   <= drop_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            fq_cnt_reg <= fq_cnt_next;
        end
    end

    // Memory must never answer when nothing is outstanding
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(mem.instr_mem_rdata_valid && (outst_reg == '0)));

    // Counter invariants
    a_drop_le_outst: assert property (@(posedge clk) disable iff (rst)
        (drop_reg <= outst_reg) && (outst_reg <= OUT_W'(MAX_OUTST)));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_used <= SUM_W'(FQ_DEPTH));

endmodule
